proc_feeder: RTL and testbench

Instruction sequencer on the driving side of the `proc` Run/Done interface. It holds a small program memory loaded by a host. On Start it issues each word on DIN with a one-cycle Run pulse and supplies the `mvi` immediate in the following cycle. It waits for `proc`'s Done before advancing and reports completion or protocol errors.

---
 rtl/proc_feeder_if.sv | 28 ++
 rtl/proc_feeder.sv | 159 +++++++++++++++
 tb/tb_proc_feeder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/proc_feeder_if.sv
// Host and proc-side signals of the proc_feeder instruction sequencer.
// The feeder uses the master modport; the host/proc side uses slave.
interface proc_feeder_if #(
    parameter int AW = 5
);
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [8:0]    WrData;
    logic [AW:0]   Length;
    logic          Start;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic          Busy;
    logic          Finished;
    logic          Error;
    logic [AW:0]   PC;

    modport master (
        input  WrEn, WrAddr, WrData, Length, Start, Done,
        output DIN, Run, Busy, Finished, Error, PC
    );

    modport slave (
        output WrEn, WrAddr, WrData, Length, Start, Done,
        input  DIN, Run, Busy, Finished, Error, PC
    );
endinterface

// File: rtl/proc_feeder.sv
// proc_feeder: drives the proc Run/Done interface from a host-loaded
// program memory. Each instruction is issued with a one-cycle Run pulse.
// An mvi immediate is presented on DIN during the following WAIT cycle.
// The next instruction is issued only after proc returns Done. Illegal
// opcodes, a truncated mvi and a Done timeout raise a sticky Error.
module proc_feeder #(
    parameter int AW  = 5,
    parameter int TMO = 4
) (
    input logic            Clock,
    input logic            Resetn,
    proc_feeder_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int          WDW     = $clog2(TMO + 1);
    localparam logic [AW:0] PC_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PC_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [WDW-1:0] WD_ZERO = {WDW{1'b0}};
    localparam logic [WDW-1:0] WD_ONE  = {{(WDW-1){1'b0}}, 1'b1};
    localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

    // Opcode 1xx is never acknowledged by proc.
    function automatic logic op_is_illegal(input logic [8:0] w);
        return w[8];
    endfunction

    // mvi carries its immediate in the following word.
    function automatic logic op_is_mvi(input logic [8:0] w);
        return (w[8:6] == 3'b001);
    endfunction

    state_t         state_r, state_s;
    logic [AW:0]    pc_r, pc_s;
    logic [AW:0]    len_r, len_s;
    logic [WDW-1:0] wd_r, wd_s;
    logic           fin_r, fin_s;
    logic           err_r, err_s;
    logic           run_s;
    logic [8:0]     din_s;
    logic [8:0]     word_s;
    logic [AW:0]    pc_inc_s;
    logic           last_s;

    logic [8:0]     mem_r [2**AW];

    assign word_s   = mem_r[pc_r[AW-1:0]];
    assign pc_inc_s = pc_r + PC_ONE;
    assign last_s   = (pc_inc_s == len_r);

    // Program memory: host writes only while the sequencer is idle; no reset.
    always_ff @(posedge Clock) begin
        if (bus.WrEn && (state_r == ST_IDLE)) begin
            mem_r[bus.WrAddr] <= bus.WrData;
        end
    end

    // State, pointer, watchdog and registered status flags.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
            len_r   <= PC_ZERO;
            wd_r    <= WD_ZERO;
            fin_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            len_r   <= len_s;
            wd_r    <= wd_s;
            fin_r   <= fin_s;
            err_r   <= err_s;
        end
    end

    // Next-state logic and the combinational Run/DIN drive.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        len_s   = len_r;
        wd_s    = wd_r;
        fin_s   = 1'b0;
        err_s   = err_r;
        run_s   = 1'b0;
        din_s   = 9'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    len_s = bus.Length;
                    pc_s  = PC_ZERO;
                    err_s = 1'b0;
                    wd_s  = WD_ZERO;
                    if (bus.Length == PC_ZERO) begin
                        fin_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                din_s = word_s;
                // A trailing mvi has no immediate word to follow it.
                if (op_is_illegal(word_s) || (op_is_mvi(word_s) && last_s)) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    run_s   = 1'b1;
                    wd_s    = WD_ZERO;
                    state_s = ST_WAIT;
                    if (op_is_mvi(word_s)) begin
                        pc_s = pc_inc_s;
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
            ST_WAIT: begin
                // For mvi the pointer already sits on the immediate.
                din_s = word_s;
                if (bus.Done) begin
                    pc_s = pc_inc_s;
                    wd_s = WD_ZERO;
                    if (last_s) begin
                        fin_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end else if (wd_r == WD_LAST) begin
                    err_s   = 1'b1;
                    wd_s    = WD_ZERO;
                    state_s = ST_IDLE;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.DIN      = din_s;
    assign bus.Run      = run_s;
    assign bus.Busy     = (state_r != ST_IDLE);
    assign bus.Finished = fin_r;
    assign bus.Error    = err_r;
    assign bus.PC       = pc_r;

endmodule

// File: tb/tb_proc_feeder.sv
// Testbench for proc_feeder with a small behavioural proc model.
module tb_proc_feeder;
    localparam int AW  = 5;
    localparam int TMO = 4;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    proc_feeder_if #(.AW(AW)) bus();

    proc_feeder #(.AW(AW), .TMO(TMO)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    // ---------------- behavioural proc model ----------------
    logic       proc_clr_n = 1'b1;
    logic       stub = 1'b0;
    wire        proc_rn = Resetn & proc_clr_n;
    logic [1:0] pt;
    logic [8:0] ir, ra, rg;
    logic [8:0] rr [8];

    assign bus.Done = !stub && (((pt == 2'd1) && (ir[8:7] == 2'b00)) || (pt == 2'd3));

    always @(posedge Clock or negedge proc_rn) begin
        if (!proc_rn) begin
            pt <= 2'd0; ir <= 9'd0; ra <= 9'd0; rg <= 9'd0;
            for (int i = 0; i < 8; i++) rr[i] <= 9'd0;
        end else begin
            case (pt)
                2'd0: if (bus.Run) begin ir <= bus.DIN; pt <= 2'd1; end
                2'd1: begin
                    case (ir[8:6])
                        3'b000: begin rr[ir[5:3]] <= rr[ir[2:0]]; pt <= 2'd0; end
                        3'b001: begin rr[ir[5:3]] <= bus.DIN; pt <= 2'd0; end
                        3'b010, 3'b011: begin ra <= rr[ir[5:3]]; pt <= 2'd2; end
                        default: pt <= 2'd1;
                    endcase
                end
                2'd2: begin
                    rg <= (ir[8:6] == 3'b010) ? ra + rr[ir[2:0]] : ra - rr[ir[2:0]];
                    pt <= 2'd3;
                end
                default: begin rr[ir[5:3]] <= rg; pt <= 2'd0; end
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_word(input int addr, input int data);
        @(negedge Clock);
        bus.WrEn = 1'b1; bus.WrAddr = AW'(addr); bus.WrData = 9'(data);
        @(posedge Clock);
        #1 bus.WrEn = 1'b0;
    endtask

    task automatic clear_proc();
        @(negedge Clock);
        proc_clr_n = 1'b0;
        #1 proc_clr_n = 1'b1;
    endtask

    // Start is sampled at edge 0; the caller's next negedge is in cycle 1.
    task automatic start_prog(input int len);
        @(negedge Clock);
        bus.Length = 6'(len); bus.Start = 1'b1;
        @(posedge Clock);
        #1 bus.Start = 1'b0;
    endtask

    // mvi R0,5; mvi R1,3; add R0,R1; mv R2,R0; sub R2,R1
    task automatic run_prog_a(input string tag);
        int iss [8];
        int n_iss;
        int fin_cyc;
        int exp_iss [5];
        exp_iss = '{1, 3, 5, 9, 11};
        n_iss = 0; fin_cyc = 0;
        clear_proc();
        start_prog(7);
        for (int c = 1; c <= 25; c++) begin
            @(negedge Clock);
            if (bus.Run && n_iss < 8) begin iss[n_iss] = c; n_iss++; end
            if (bus.Finished && fin_cyc == 0) fin_cyc = c;
            if (c == 1) check({tag, " din_c1"}, int'(bus.DIN), 'h040);
            if (c == 2) check({tag, " din_c2"}, int'(bus.DIN), 'h005);
            if (c == 2) check({tag, " run_c2"}, int'(bus.Run), 0);
            if (c == 3) check({tag, " r0_mvi"}, int'(rr[0]), 5);
        end
        check({tag, " issue_count"}, n_iss, 5);
        for (int i = 0; i < 5; i++)
            if (i < n_iss) check({tag, " issue_cycle"}, iss[i], exp_iss[i]);
        check({tag, " fin_cycle"}, fin_cyc, 15);
        check({tag, " r0"}, int'(rr[0]), 8);
        check({tag, " r2"}, int'(rr[2]), 5);
        check({tag, " pc"}, int'(bus.PC), 7);
        check({tag, " err"}, int'(bus.Error), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [8:0] w0;
        logic [8:0] w1;
        int         len;
        int         runs;
        int         err;
        int         fins;
        int         pc;
        int         flag_cyc;
    } vec_t;

    vec_t vt [7];

    initial begin
        int runs, fins, flag;
        bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0;
        bus.Length = '0; bus.Start = 1'b0;

        vt[0] = '{9'h040, 9'h005, 2, 1, 0, 1, 2, 3};   // mvi R0,5
        vt[1] = '{9'h180, 9'h000, 1, 0, 1, 0, 0, 2};   // illegal opcode
        vt[2] = '{9'h040, 9'h000, 1, 0, 1, 0, 0, 2};   // mvi as last word
        vt[3] = '{9'h040, 9'h000, 0, 0, 0, 1, 0, 1};   // Length=0 clears Error
        vt[4] = '{9'h008, 9'h000, 1, 1, 0, 1, 1, 3};   // mv R1,R0
        vt[5] = '{9'h080, 9'h000, 1, 1, 0, 1, 1, 5};   // add R0,R0
        vt[6] = '{9'h0DB, 9'h000, 1, 1, 0, 1, 1, 5};   // sub R3,R3

        // Reset values
        repeat (2) @(negedge Clock);
        check("rst din", int'(bus.DIN), 0);
        check("rst run", int'(bus.Run), 0);
        check("rst busy", int'(bus.Busy), 0);
        check("rst fin", int'(bus.Finished), 0);
        check("rst err", int'(bus.Error), 0);
        check("rst pc", int'(bus.PC), 0);
        Resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            clear_proc();
            write_word(0, int'(vt[i].w0));
            write_word(1, int'(vt[i].w1));
            start_prog(vt[i].len);
            runs = 0; fins = 0; flag = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge Clock);
                if (bus.Run) runs++;
                if (bus.Finished) fins++;
                if (flag == 0 && (bus.Finished || bus.Error)) flag = c;
            end
            check($sformatf("vec%0d runs", i), runs, vt[i].runs);
            check($sformatf("vec%0d fins", i), fins, vt[i].fins);
            check($sformatf("vec%0d err", i), int'(bus.Error), vt[i].err);
            check($sformatf("vec%0d pc", i), int'(bus.PC), vt[i].pc);
            check($sformatf("vec%0d busy", i), int'(bus.Busy), 0);
            check($sformatf("vec%0d flag_cycle", i), flag, vt[i].flag_cyc);
        end

        // Five-instruction program
        write_word(0, 'h040); write_word(1, 'h005);
        write_word(2, 'h048); write_word(3, 'h003);
        write_word(4, 'h081); write_word(5, 'h010);
        write_word(6, 'h0D1);
        run_prog_a("progA");

        // Watchdog with Done held low
        write_word(7, 'h008);
        write_word(0, 'h008);
        clear_proc();
        stub = 1'b1;
        start_prog(1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clock);
            if (c == 1) check("wd run_c1", int'(bus.Run), 1);
            if (c == 5) check("wd err_c5", int'(bus.Error), 0);
            if (c == 5) check("wd busy_c5", int'(bus.Busy), 1);
            if (c == 6) check("wd err_c6", int'(bus.Error), 1);
            if (c == 6) check("wd busy_c6", int'(bus.Busy), 0);
            if (c == 6) check("wd fin_c6", int'(bus.Finished), 0);
        end
        stub = 1'b0;
        write_word(0, 'h040);

        // Reset in the second WAIT cycle of add; write attempted while busy
        clear_proc();
        start_prog(7);
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clock);
            if (c == 3) begin bus.WrEn = 1'b1; bus.WrAddr = '0; bus.WrData = 9'h1FF; end
            if (c == 4) bus.WrEn = 1'b0;
        end
        check("pre-rst busy", int'(bus.Busy), 1);
        #1 Resetn = 1'b0;
        #1;
        check("midrst run", int'(bus.Run), 0);
        check("midrst busy", int'(bus.Busy), 0);
        check("midrst pc", int'(bus.PC), 0);
        check("midrst din", int'(bus.DIN), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        run_prog_a("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
